// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the shared combinational instruction memory between the fetch stage and a debug/trace port.
// Grants one request per cycle and returns registered data, with debug starvation protection and an exclusive lock mode.
module imem_fetch_arbiter #(
  parameter int ADDR_BITS    = 9,
  parameter int MEM_WORDS    = 396,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_err,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  output logic        dbg_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr
);

  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic {
    S_NORMAL,
    S_DBG_LOCK
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starveCnt_q, starveCnt_d;

  logic            fetchGnt, dbgGnt;
  logic            fetchBad, dbgBad;
  logic [31:0]     grantAddr;

  logic            fetchValid_q, fetchErr_q;
  logic [31:0]     fetchInstr_q;
  logic            dbgValid_q, dbgErr_q;
  logic [31:0]     dbgData_q;

  function automatic logic addrInvalid(input logic [31:0] addr);
    logic [ADDR_BITS-1:0] wordIdx;
    wordIdx = addr[ADDR_BITS+1:2];
    return (addr[1:0] != 2'b00) ||
           (addr[31:ADDR_BITS+2] != '0) ||
           (32'(wordIdx) >= 32'(MEM_WORDS));
  endfunction

  assign fetchBad = addrInvalid(fetch_addr);
  assign dbgBad   = addrInvalid(dbg_addr);

  // Grants are suppressed while Reset is high so every output reads 0 during reset.
  always_comb begin
    fetchGnt = 1'b0;
    dbgGnt   = 1'b0;
    if (!Reset) begin
      if (state_q == S_DBG_LOCK) begin
        dbgGnt = dbg_req;
      end else if (fetch_req && dbg_req) begin
        if (starveCnt_q == StarveMax) begin
          dbgGnt = 1'b1;
        end else begin
          fetchGnt = 1'b1;
        end
      end else begin
        fetchGnt = fetch_req;
        dbgGnt   = dbg_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_NORMAL:   if (dbgGnt && dbg_lock) state_d = S_DBG_LOCK;
      S_DBG_LOCK: if (!dbg_lock)          state_d = S_NORMAL;
      default:                            state_d = S_NORMAL;
    endcase
  end

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (dbgGnt) begin
      starveCnt_d = '0;
    end else if (dbg_req && (starveCnt_q != StarveMax)) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  always_comb begin
    grantAddr = 32'h0;
    if (dbgGnt) begin
      grantAddr = dbg_addr;
    end else if (fetchGnt) begin
      grantAddr = fetch_addr;
    end
  end

  // Response data follows whichever requester was granted; it holds between pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_NORMAL;
      starveCnt_q  <= '0;
      fetchValid_q <= 1'b0;
      fetchErr_q   <= 1'b0;
      fetchInstr_q <= 32'h0;
      dbgValid_q   <= 1'b0;
      dbgErr_q     <= 1'b0;
      dbgData_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      starveCnt_q  <= starveCnt_d;
      fetchValid_q <= fetchGnt;
      dbgValid_q   <= dbgGnt;
      if (fetchGnt) begin
        fetchErr_q   <= fetchBad;
        fetchInstr_q <= fetchBad ? 32'h0 : mem_instr;
      end
      if (dbgGnt) begin
        dbgErr_q  <= dbgBad;
        dbgData_q <= dbgBad ? 32'h0 : mem_instr;
      end
    end
  end

  // Registered outputs are masked during Reset so a pending response is dropped.
  assign fetch_gnt   = fetchGnt;
  assign dbg_gnt     = dbgGnt;
  assign mem_addr    = {grantAddr[31:2], 2'b00};
  assign fetch_valid = fetchValid_q & ~Reset;
  assign fetch_err   = fetchErr_q & ~Reset;
  assign fetch_instr = Reset ? 32'h0 : fetchInstr_q;
  assign dbg_valid   = dbgValid_q & ~Reset;
  assign dbg_err     = dbgErr_q & ~Reset;
  assign dbg_data    = Reset ? 32'h0 : dbgData_q;

endmodule
